// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: turns the EX/MEM load/store into a
// req/gnt/rvalid bus transaction, stalls the pipe and formats load data.
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_m,
    input  logic                  load_m,
    input  logic                  mem_wem,
    input  logic [2:0]            opm,
    input  logic [ADDR_WIDTH-1:0] alu_resultm,
    input  logic [DATA_WIDTH-1:0] rd2_turem,
    input  logic                  flush_m,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_wstrb,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  wb_en_o,
    output logic                  misalign_o,
    output logic                  bus_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    // Access size from funct3: 0 = byte, 1 = halfword, 2 = word (undefined codes act as word).
    function automatic logic [1:0] size_code(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: size_code = 2'd0;
            3'b001, 3'b101: size_code = 2'd1;
            default:        size_code = 2'd2;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        case (size_code(op))
            2'd0:    is_misaligned = 1'b0;
            2'd1:    is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] op, input logic [1:0] off);
        case (size_code(op))
            2'd0:    store_strb = 4'b0001 << off;
            2'd1:    store_strb = 4'b0011 << off;
            default: store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] op, input logic [31:0] data);
        case (size_code(op))
            2'd0:    store_lanes = {4{data[7:0]}};
            2'd1:    store_lanes = {2{data[15:0]}};
            default: store_lanes = data;
        endcase
    endfunction

    function automatic logic [31:0] format_load(input logic [2:0] op, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0] shifted;
        shifted = rdata >> {off, 3'b000};
        case (op)
            3'b000:  format_load = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  format_load = {24'd0, shifted[7:0]};
            3'b001:  format_load = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  format_load = {16'd0, shifted[15:0]};
            default: format_load = rdata;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [2:0]              op_q, op_d;
    logic [1:0]              off_q, off_d;
    logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    kill_q, kill_d;
    logic                    err_q, err_d;

    logic                    pending_s;
    logic                    mis_s;
    logic [1:0]              off_s;

    assign off_s     = alu_resultm[1:0];
    assign pending_s = valid_m & (load_m | mem_wem) & ~flush_m;
    assign mis_s     = is_misaligned(opm, off_s);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wstrb_q     <= 4'b0000;
            wdata_q     <= '0;
            op_q        <= 3'b000;
            off_q       <= 2'b00;
            load_data_q <= '0;
            cnt_q       <= 8'd0;
            kill_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            op_q        <= op_d;
            off_q       <= off_d;
            load_data_q <= load_data_d;
            cnt_q       <= cnt_d;
            kill_q      <= kill_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_s && !mis_s) state_d = ST_REQ;
                else                     state_d = ST_IDLE;
            end
            ST_REQ: begin
                if (dmem_gnt) begin
                    if (we_q || dmem_rvalid) state_d = ST_DONE;
                    else                     state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid || (cnt_q == TMO_LAST)) state_d = ST_DONE;
                else                                    state_d = ST_WAIT;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latching, wait counter, kill/error flags and load capture.
    always_comb begin
        addr_d      = addr_q;
        we_d        = we_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        op_d        = op_q;
        off_d       = off_q;
        load_data_d = load_data_q;
        cnt_d       = cnt_q;
        kill_d      = kill_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_s && !mis_s) begin
                    addr_d  = {alu_resultm[ADDR_WIDTH-1:2], 2'b00};
                    we_d    = mem_wem;
                    wstrb_d = mem_wem ? store_strb(opm, off_s) : 4'b0000;
                    wdata_d = store_lanes(opm, rd2_turem);
                    op_d    = opm;
                    off_d   = off_s;
                    cnt_d   = 8'd0;
                    kill_d  = 1'b0;
                    err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_REQ: begin
                kill_d = kill_q | flush_m;
                cnt_d  = 8'd0;
                if (dmem_gnt && !we_q && dmem_rvalid) begin
                    load_data_d = format_load(op_q, off_q, dmem_rdata);
                end else begin
                    load_data_d = load_data_q;
                end
            end
            ST_WAIT: begin
                kill_d = kill_q | flush_m;
                if (dmem_rvalid) begin
                    load_data_d = format_load(op_q, off_q, dmem_rdata);
                end else if (cnt_q == TMO_LAST) begin
                    load_data_d = '0;
                    err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: cnt_d = 8'd0;
            default: cnt_d = 8'd0;
        endcase
    end

    // Output decode; stall and misalign react combinationally in IDLE.
    always_comb begin
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        wb_en_o    = 1'b0;
        bus_err_o  = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_wstrb = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                stall_o    = pending_s & ~mis_s;
                misalign_o = pending_s & mis_s;
            end
            ST_REQ: begin
                stall_o    = 1'b1;
                dmem_req   = 1'b1;
                dmem_we    = we_q;
                dmem_wstrb = wstrb_q;
            end
            ST_WAIT: stall_o = 1'b1;
            ST_DONE: begin
                wb_en_o   = ~we_q & ~err_q & ~kill_q;
                bus_err_o = err_q & ~kill_q;
            end
            default: stall_o = 1'b0;
        endcase
    end

    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign load_data  = load_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver pushes expected bus
// requests and completions, an independent monitor pops and compares them.
module tb_mem_access_ctrl;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_m, load_m, mem_wem, flush_m;
    logic [2:0]  opm;
    logic [31:0] alu_resultm, rd2_turem;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_o, wb_en_o, misalign_o, bus_err_o;
    logic [31:0] load_data;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .load_m(load_m), .mem_wem(mem_wem),
        .opm(opm), .alu_resultm(alu_resultm), .rd2_turem(rd2_turem), .flush_m(flush_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .stall_o(stall_o), .load_data(load_data), .wb_en_o(wb_en_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    typedef struct { logic [31:0] addr; logic we; logic [3:0] strb; logic [31:0] wdata; } bus_exp_t;
    typedef struct { int stall; logic wb; logic be; logic [31:0] ld; } done_exp_t;

    bus_exp_t    bus_q[$];
    done_exp_t   done_q[$];
    int          mis_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        mon_en   = 1'b0;
    logic [31:0] ld_model;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on access size and byte offset.
    function automatic int size_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] op, input int off);
        int sz;
        sz = size_of(op);
        if (sz == 1) return 4'(1 << off);
        if (sz == 2) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] wd);
        int sz;
        sz = size_of(op);
        if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input int off, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * off);
        case (op)
            3'd0: return ((v & 32'hFF) >= 32'd128) ? ((v & 32'hFF) + 32'hFFFF_FF00) : (v & 32'hFF);
            3'd4: return v & 32'hFF;
            3'd1: return ((v & 32'hFFFF) >= 32'd32768) ? ((v & 32'hFFFF) + 32'hFFFF_0000) : (v & 32'hFFFF);
            3'd5: return v & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    // Drive one access starting in IDLE; gnt after g REQ cycles, rvalid r cycles after gnt
    // (r > TIMEOUT means never), flush pulse at busy-cycle kill_at (-1 = none).
    task automatic run_access(input logic ld_i, input logic st_i, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] wd, input int g,
                              input int r, input int kill_at, input logic [31:0] rdata);
        int        sz, waitc, cyc;
        logic      ld, err, killed;
        bus_exp_t  be;
        done_exp_t de;
        ld = ld_i && !st_i;
        sz = size_of(op);
        valid_m = 1'b1; load_m = ld_i; mem_wem = st_i; opm = op;
        alu_resultm = addr; rd2_turem = wd; flush_m = 1'b0;
        if ((int'(addr[1:0]) % sz) != 0) begin
            mis_q.push_back(1);
            @(posedge clk); #1;
            valid_m = 1'b0; load_m = 1'b0; mem_wem = 1'b0;
            return;
        end
        be.addr  = addr & 32'hFFFF_FFFC;
        be.we    = st_i;
        be.strb  = ref_strb(op, int'(addr[1:0]));
        be.wdata = ref_wdata(op, wd);
        bus_q.push_back(be);
        waitc  = (ld && r > 0) ? ((r <= TIMEOUT) ? r : TIMEOUT) : 0;
        err    = ld && (r > TIMEOUT);
        killed = (kill_at >= 0);
        if (ld) ld_model = err ? 32'h0 : ref_load(op, int'(addr[1:0]), rdata);
        de.stall = 2 + g + waitc;
        de.wb    = ld && !err && !killed;
        de.be    = err && !killed;
        de.ld    = ld_model;
        done_q.push_back(de);
        @(posedge clk); #1;
        cyc = 0;
        for (int i = 0; i <= g; i++) begin
            dmem_gnt    = (i == g);
            dmem_rvalid = (i == g) && ld && (r == 0);
            dmem_rdata  = rdata;
            flush_m     = (cyc == kill_at);
            @(posedge clk); #1;
            cyc++;
        end
        dmem_gnt = 1'b0;
        for (int i = 1; i <= waitc; i++) begin
            dmem_rvalid = (i == r);
            flush_m     = (cyc == kill_at);
            @(posedge clk); #1;
            cyc++;
        end
        valid_m = 1'b0; load_m = 1'b0; mem_wem = 1'b0; flush_m = 1'b0;
        dmem_gnt    = 1'($urandom_range(0, 1));
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
        @(posedge clk); #1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    task automatic idle_flush();
        valid_m = 1'b1; load_m = 1'b1; mem_wem = 1'b0; opm = 3'd2;
        alu_resultm = 32'h0000_0040; flush_m = 1'b1;
        @(posedge clk); #1;
        valid_m = 1'b0; load_m = 1'b0; flush_m = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a request, completion or misalign.
    initial begin : monitor
        int        stall_cnt;
        logic      prev_stall;
        bus_exp_t  eb;
        done_exp_t ed;
        stall_cnt  = 0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                stall_cnt  = 0;
                prev_stall = 1'b0;
            end else begin
                if (dmem_req && dmem_gnt) begin
                    chk("req_expected", 32'(bus_q.size() > 0), 32'd1);
                    if (bus_q.size() > 0) begin
                        eb = bus_q.pop_front();
                        chk("dmem_addr", dmem_addr, eb.addr);
                        chk("dmem_we", 32'(dmem_we), 32'(eb.we));
                        if (eb.we) begin
                            chk("dmem_wstrb", 32'(dmem_wstrb), 32'(eb.strb));
                            chk("dmem_wdata", dmem_wdata, eb.wdata);
                        end
                    end
                end
                if (misalign_o) begin
                    chk("misalign_expected", 32'(mis_q.size() > 0), 32'd1);
                    if (mis_q.size() > 0) void'(mis_q.pop_front());
                    chk("misalign_req", 32'(dmem_req), 32'd0);
                    chk("misalign_stall", 32'(stall_o), 32'd0);
                end
                if (stall_o) begin
                    stall_cnt++;
                end else if (prev_stall) begin
                    chk("done_expected", 32'(done_q.size() > 0), 32'd1);
                    if (done_q.size() > 0) begin
                        ed = done_q.pop_front();
                        chk("stall_cycles", 32'(stall_cnt), 32'(ed.stall));
                        chk("wb_en_o", 32'(wb_en_o), 32'(ed.wb));
                        chk("bus_err_o", 32'(bus_err_o), 32'(ed.be));
                        chk("load_data", load_data, ed.ld);
                    end
                    stall_cnt = 0;
                end else if (wb_en_o || bus_err_o) begin
                    chk("spurious_pulse", {30'd0, wb_en_o, bus_err_o}, 32'd0);
                end
                prev_stall = stall_o;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [2:0]  op;
        logic [31:0] addr;
        logic        ld_i, st_i;
        int          sz, g, r, rsel, kind, kill_at, busy;
        rst_n = 1'b0; valid_m = 1'b0; load_m = 1'b0; mem_wem = 1'b0; flush_m = 1'b0;
        opm = 3'd0; alu_resultm = 32'h0; rd2_turem = 32'h0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0; ld_model = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wstrb", 32'(dmem_wstrb), 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_flags", {29'd0, wb_en_o, misalign_o, bus_err_o}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        run_access(1'b0, 1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, -1, 32'h0);
        run_access(1'b1, 1'b0, 3'd0, 32'h0000_0203, 32'h0, 0, 3, -1, 32'h80FF_FF7F);
        run_access(1'b1, 1'b0, 3'd5, 32'h0000_0202, 32'h0, 0, 0, -1, 32'h8001_1234);
        run_access(1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0, 0, 0, -1, 32'h0);
        run_access(1'b0, 1'b1, 3'd0, 32'h0000_0001, 32'h0000_00AB, 0, 0, -1, 32'h0);
        run_access(1'b1, 1'b0, 3'd2, 32'h0000_0300, 32'h0, 0, 255, -1, 32'h1234_5678);
        run_access(1'b1, 1'b0, 3'd2, 32'h0000_0400, 32'h0, 0, 2, 1, 32'hCAFE_F00D);
        idle_flush();
        run_access(1'b1, 1'b1, 3'd1, 32'h0000_0502, 32'h0000_9876, 2, 0, -1, 32'h0);

        // Asynchronous reset while a load sits in REQ.
        mon_en = 1'b0;
        valid_m = 1'b1; load_m = 1'b1; opm = 3'd2; alu_resultm = 32'h0000_0600;
        @(posedge clk); #1;
        chk("req_before_reset", 32'(dmem_req), 32'd1);
        valid_m = 1'b0; load_m = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_drops_req", 32'(dmem_req), 32'd0);
        chk("reset_stall", 32'(stall_o), 32'd0);
        chk("reset_load_data", load_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("idle_after_reset_req", 32'(dmem_req), 32'd0);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        ld_model = 32'h0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        run_access(1'b0, 1'b1, 3'd1, 32'h0000_0702, 32'h0000_5A5A, 1, 0, -1, 32'h0);

        for (int t = 0; t < 200; t++) begin
            op   = 3'($urandom_range(0, 7));
            kind = int'($urandom_range(0, 9));
            ld_i = (kind <= 4) || (kind == 9);
            st_i = (kind >= 5);
            sz   = size_of(op);
            addr = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 4) addr[1:0] = 2'b00;
                else if (sz == 2) addr[0] = 1'b0;
                else addr[0] = addr[0];
            end
            g    = int'($urandom_range(0, 3));
            rsel = int'($urandom_range(0, 19));
            if (rsel < 14) r = int'($urandom_range(0, 4));
            else if (rsel < 17) r = TIMEOUT - 1 + (rsel - 14);
            else r = 255;
            busy = 1 + g + ((ld_i && !st_i && r > 0) ? ((r <= TIMEOUT) ? r : TIMEOUT) : 0);
            kill_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, busy - 1)) : -1;
            if ($urandom_range(0, 19) == 0) idle_flush();
            run_access(ld_i, st_i, op, addr, $urandom, g, r, kill_at, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        chk("done_queue_drained", 32'(done_q.size()), 32'd0);
        chk("misalign_queue_drained", 32'(mis_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the MEM stage's data-memory port. Sits after the EX/MEM pipeline register; converts each load/store held there into a req/gnt/rvalid transaction on the data-memory bus, stalls the pipeline until the access completes, and returns sign/zero-extended load data to write-back. Detects misaligned accesses and bus timeouts.

## Interface
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- ADDR_WIDTH, 32, address width.
- TIMEOUT, 16, maximum cycles in WAIT before bus error; legal range 2..255.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_m  in  1  MEM-stage slot holds a live instruction.
- load_m  in  1  instruction is a load.
- mem_wem  in  1  instruction is a store.
- opm  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 are treated as W.
- alu_resultm  in  ADDR_WIDTH  byte address.
- rd2_turem  in  DATA_WIDTH  store data, right-aligned.
- flush_m  in  1  kill the MEM-stage instruction.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_WIDTH  word address, with bits [1:0] = 0.
- dmem_wstrb  out  4  byte enables.
- dmem_wdata  out  DATA_WIDTH  lane-shifted store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  DATA_WIDTH  read data.
- stall_o  out  1  hold PC and all pipeline registers up to and including EX/MEM.
- load_data  out  DATA_WIDTH  formatted load result.
- wb_en_o  out  1  load result may be written back (one-cycle pulse).
- misalign_o  out  1  misaligned access detected (one-cycle pulse).
- bus_err_o  out  1  timeout (one-cycle pulse).

## Operation
- An access is pending when valid_m & (load_m | mem_wem) & ~flush_m. If load_m and mem_wem are both 1, the access is treated as a store.
- Misalignment:
  - H/HU with addr[0] = 1 is misaligned.
  - W with addr[1:0] ≠ 0 is misaligned.
  - A misaligned access issues no request. misalign_o is asserted combinationally while in IDLE, and stall_o stays 0.
- States are IDLE, REQ, WAIT and DONE.
- IDLE:
  - A pending aligned access asserts stall_o combinationally.
  - On the next edge the controller latches addr, we, wstrb, wdata and opm, then moves to REQ.
- REQ:
  - dmem_req = 1 and all bus outputs are held stable until dmem_gnt.
  - On gnt with a store, go to DONE.
  - On gnt with a load and dmem_rvalid also 1, capture the data and go to DONE.
  - On gnt with a load and no rvalid, go to WAIT and clear the counter.
- WAIT:
  - On dmem_rvalid, capture the formatted data and go to DONE.
  - The counter increments every cycle. When it reaches TIMEOUT-1 without rvalid, set load_data = 0, pulse bus_err_o, and go to DONE.
- DONE:
  - stall_o = 0 for exactly one cycle.
  - wb_en_o = 1 only if the access was a load that completed normally and was not killed.
  - Next state is IDLE.
- Kill: flush_m asserted in REQ or WAIT sets a kill flag. The handshake still completes, because a bus transaction cannot be aborted. In DONE, wb_en_o = 0 and bus_err_o is suppressed.
- Store lanes, with off = addr[1:0]:
  - B: wstrb = 0001<<off, wdata = {4{rd2[7:0]}}.
  - H: wstrb = 0011<<off, wdata = {2{rd2[15:0]}}.
  - W: wstrb = 1111, wdata = rd2.
- Load formatting: select the byte or halfword by off from rdata. B/H sign-extend, BU/HU zero-extend, W passes through.
- Outputs when idle: dmem_req = 0, dmem_we = 0, dmem_wstrb = 0, and dmem_addr/dmem_wdata hold their last latched values.

## Timing
- Reset values: state IDLE, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wstrb 0, dmem_wdata 0, load_data 0, counter 0, kill 0. stall_o, wb_en_o, misalign_o and bus_err_o are 0 once the asynchronous reset clears the state.
- Reset mid-access returns to IDLE immediately and drops dmem_req. Any outstanding memory response is ignored.
- Minimum stall:
  - Store with gnt in the first REQ cycle: 2 cycles (IDLE, REQ), then DONE.
  - Load with gnt+rvalid together: same as the store case.
  - Load with rvalid one cycle after gnt: 3 stall cycles.
- load_data is registered. It is valid in DONE and holds until the next load capture.
- dmem_rvalid outside REQ/WAIT and dmem_gnt outside REQ are ignored.
- The pending condition is evaluated only in IDLE. In DONE the EX/MEM register advances, so a new access is seen in the following IDLE cycle, giving no back-to-back issue.

## Test plan
- SW at addr 0x100, data 0xDEADBEEF, gnt in the first REQ cycle -> dmem_addr = 0x100, wstrb = 1111, dmem_we = 1; stall_o high for 2 cycles, then DONE with wb_en_o = 0.
- LB at addr 0x203, rdata = 0x80FF_FF7F delivered 3 cycles after gnt -> load_data = 0xFFFF_FF80, wb_en_o pulses once in DONE.
- LHU at addr 0x202, rdata = 0x8001_1234 with gnt and rvalid together -> load_data = 0x0000_8001; 2 stall cycles.
- LW at addr 0x101 -> misalign_o = 1, dmem_req stays 0, stall_o = 0. Separately, SB at addr 0x1 with data 0xAB -> wstrb = 0010, wdata = 0xABABABAB.
- LW with rvalid never asserted, TIMEOUT = 16 -> bus_err_o pulses after 16 WAIT cycles, load_data = 0, wb_en_o = 0.
- flush_m raised in WAIT of an LW, then rvalid arrives -> DONE with wb_en_o = 0. Separately, rst_n dropped in REQ -> dmem_req falls asynchronously and state returns to IDLE.
